wordle_letter_entry: RTL and testbench

Producer side of the letter interface into the Wordle guess state machine. The player uses debounced button pulses to scroll through the letters A-Z, commit a letter, or request a backspace. Each committed symbol is presented as an 8-bit ASCII code on curr_letter and held under a Valid/Ack handshake. A position counter tracks entry into the current WORD_LEN-letter guess and drives the display cursor.

---
 rtl/wordle_letter_entry_if.sv | 10 +
 rtl/wordle_letter_entry.sv | 127 ++++++++++++
 tb/tb_wordle_letter_entry.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wordle_letter_entry_if.sv
// Letter handshake between the entry block (producer) and the guess FSM (consumer).
// curr_letter is only meaningful while Valid is high; Ack is sampled only then.
interface wordle_letter_entry_if;
    logic [7:0] curr_letter;
    logic       Valid;
    logic       Ack;

    modport master (output curr_letter, output Valid, input Ack);
    modport slave  (input curr_letter, input Valid, output Ack);
endinterface

// File: rtl/wordle_letter_entry.sv
// Wordle letter entry: scroll A-Z with BtnU/BtnD, commit with BtnC, backspace
// with BtnL. Each symbol is offered on the letter interface and held until Ack.
// pos counts accepted letters in the current guess and drives the cursor.
module wordle_letter_entry #(
    parameter int unsigned WORD_LEN     = 5,
    parameter logic [7:0]  FIRST_LETTER = 8'h41,
    parameter logic [7:0]  LAST_LETTER  = 8'h5A,
    parameter logic [7:0]  BKSP_CODE    = 8'h08
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          En,
    input  logic                          BtnU,
    input  logic                          BtnD,
    input  logic                          BtnC,
    input  logic                          BtnL,
    wordle_letter_entry_if.master         lif,
    output logic [7:0]                    sel_letter,
    output logic [2:0]                    pos,
    output logic                          word_full
);

    localparam logic [2:0] WLEN = 3'(WORD_LEN);

    typedef enum logic [2:0] {
        QIDLE  = 3'b001,
        QSEL   = 3'b010,
        QOFFER = 3'b100
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sel_q, sel_d;
    logic [7:0] curr_q, curr_d;
    logic       valid_q, valid_d;
    logic [2:0] pos_q, pos_d;
    logic       bksp_q, bksp_d;   // pending offer is a backspace, not a letter

    // State register; reset pre-empts everything, including an open offer.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= QIDLE;
            sel_q   <= FIRST_LETTER;
            curr_q  <= 8'h00;
            valid_q <= 1'b0;
            pos_q   <= 3'd0;
            bksp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            curr_q  <= curr_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            bksp_q  <= bksp_d;
        end
    end

    // Next-state: selection, commit/backspace offers and the Ack return path.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        curr_d  = curr_q;
        valid_d = valid_q;
        pos_d   = pos_q;
        bksp_d  = bksp_q;
        unique case (state_q)
            QIDLE: begin
                valid_d = 1'b0;
                if (En) begin
                    state_d = QSEL;
                    pos_d   = 3'd0;
                    sel_d   = FIRST_LETTER;
                end
            end
            QSEL: begin
                if (!En) begin
                    state_d = QIDLE;
                end else if (BtnC) begin
                    // A commit on a full word is swallowed; it still outranks BtnL/U/D.
                    if (pos_q < WLEN) begin
                        curr_d  = sel_q;
                        valid_d = 1'b1;
                        bksp_d  = 1'b0;
                        state_d = QOFFER;
                    end
                end else if (BtnL) begin
                    if (pos_q != 3'd0) begin
                        curr_d  = BKSP_CODE;
                        valid_d = 1'b1;
                        bksp_d  = 1'b1;
                        state_d = QOFFER;
                    end
                end else if (BtnU && !BtnD) begin
                    sel_d = (sel_q == LAST_LETTER) ? FIRST_LETTER : sel_q + 8'd1;
                end else if (BtnD && !BtnU) begin
                    sel_d = (sel_q == FIRST_LETTER) ? LAST_LETTER : sel_q - 8'd1;
                end
            end
            QOFFER: begin
                if (!En) begin
                    // pos is left as-is; it is cleared on the next QIDLE->QSEL entry.
                    state_d = QIDLE;
                    valid_d = 1'b0;
                end else if (lif.Ack) begin
                    state_d = QSEL;
                    valid_d = 1'b0;
                    if (bksp_q) begin
                        pos_d = pos_q - 3'd1;
                    end else begin
                        pos_d = pos_q + 3'd1;
                        sel_d = FIRST_LETTER;
                    end
                end
            end
            default: begin
                state_d = QIDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign lif.curr_letter = curr_q;
    assign lif.Valid       = valid_q;
    assign sel_letter      = sel_q;
    assign pos             = pos_q;
    assign word_full       = (pos_q == WLEN);

endmodule

// File: tb/tb_wordle_letter_entry.sv
// Bench for wordle_letter_entry: directed walk through the entry rules, then
// random button traffic. Expected state is queued per cycle by the driver from
// a letter-index model; a monitor pops and compares on the falling edge, and
// offered symbols are checked from a separate queue whenever Valid rises.
module tb_wordle_letter_entry;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       En = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnC = 1'b0, BtnL = 1'b0, Ack = 1'b0;
    logic [7:0] sel_letter;
    logic [2:0] pos;
    logic       word_full;

    wordle_letter_entry_if lif();
    assign lif.Ack = Ack;

    wordle_letter_entry dut (
        .Clk(Clk), .reset(reset), .En(En),
        .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC), .BtnL(BtnL),
        .lif(lif.master),
        .sel_letter(sel_letter), .pos(pos), .word_full(word_full)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the selection is an index 0..25 into the alphabet,
    // the guess is a count of accepted letters, and an offer is either open or not.
    int         m_idx, m_pos;
    bit         m_active, m_offer, m_bksp;
    logic [7:0] m_curr;

    typedef struct {
        logic       valid;
        logic [7:0] curr;
        logic [7:0] sel;
        int         pos;
        logic       full;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] letq[$];

    function automatic void model_reset();
        m_idx = 0; m_pos = 0; m_active = 0; m_offer = 0; m_bksp = 0; m_curr = 8'h00;
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
        end else if (!m_active) begin
            if (En) begin m_active = 1; m_pos = 0; m_idx = 0; end
        end else if (!En) begin
            m_active = 0; m_offer = 0;
        end else if (m_offer) begin
            if (Ack) begin
                m_offer = 0;
                if (m_bksp) m_pos = m_pos - 1;
                else begin m_pos = m_pos + 1; m_idx = 0; end
            end
        end else if (BtnC) begin
            if (m_pos < 5) begin
                m_offer = 1; m_bksp = 0; m_curr = 8'(65 + m_idx);
                letq.push_back(m_curr);
            end
        end else if (BtnL) begin
            if (m_pos > 0) begin
                m_offer = 1; m_bksp = 1; m_curr = 8'h08;
                letq.push_back(m_curr);
            end
        end else if (BtnU != BtnD) begin
            m_idx = BtnU ? (m_idx + 1) % 26 : (m_idx + 25) % 26;
        end
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        e.valid = m_offer;
        e.curr  = m_curr;
        e.sel   = 8'(65 + m_idx);
        e.pos   = m_pos;
        e.full  = (m_pos == 5);
        return e;
    endfunction

    // Apply inputs for one cycle, then predict what the edge produces.
    task automatic step(input logic en, input logic u, input logic d,
                        input logic c, input logic l, input logic ack);
        En = en; BtnU = u; BtnD = d; BtnC = c; BtnL = l; Ack = ack;
        @(posedge Clk);
        model_step();
        expq.push_back(model_view());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic commit_acked();
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1);
    endtask

    task automatic bksp_acked();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
    endtask

    // Monitor: compare the cycle's prediction; check each new offer's symbol.
    logic prev_valid = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("Valid",       int'(lif.Valid),       int'(e.valid));
            chk("curr_letter", int'(lif.curr_letter), int'(e.curr));
            chk("sel_letter",  int'(sel_letter),      int'(e.sel));
            chk("pos",         int'(pos),             e.pos);
            chk("word_full",   int'(word_full),       int'(e.full));
        end
        if (lif.Valid === 1'b1 && prev_valid !== 1'b1) begin
            if (letq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL offer: unexpected Valid with curr_letter %0h", lif.curr_letter);
            end else begin
                chk("offer_symbol", int'(lif.curr_letter), int'(letq.pop_front()));
            end
        end
        prev_valid = lif.Valid;
    end

    initial begin
        model_reset();
        #1;
        // Buttons toggled while held in reset change nothing.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 1);
        chk("rst_sel",   int'(sel_letter),      8'h41);
        chk("rst_valid", int'(lif.Valid),       0);
        chk("rst_curr",  int'(lif.curr_letter), 0);
        reset = 1'b1;
        step(1, 0, 0, 0, 0, 0);            // enter selection
        step(1, 0, 1, 0, 0, 0);            // A -> Z
        step(1, 1, 0, 0, 0, 0);            // Z -> A
        step(1, 1, 0, 0, 0, 0);            // A -> B
        step(1, 1, 1, 0, 0, 0);            // both: unchanged
        step(1, 1, 0, 0, 0, 0);            // B -> C
        step(1, 0, 0, 1, 0, 0);            // commit 'C'
        for (int i = 0; i < 4; i++) step(1, i[0], 0, 0, 0, 0);  // held, presses lost
        step(1, 0, 0, 0, 0, 1);            // Ack -> pos 1
        step(1, 0, 0, 0, 0, 1);            // Ack held over: ignored
        for (int i = 0; i < 4; i++) commit_acked();              // pos 5, full
        step(1, 0, 0, 1, 0, 0);            // 6th commit ignored
        idle(1);
        bksp_acked();                      // 08 offered, pos 4
        for (int i = 0; i < 4; i++) bksp_acked();                // pos 0
        step(1, 0, 0, 0, 1, 0);            // backspace at 0 ignored
        idle(1);
        step(1, 0, 0, 1, 0, 0);            // offer open
        step(0, 0, 0, 0, 0, 1);            // En drop wins over Ack
        step(1, 0, 0, 0, 0, 0);            // re-entry clears pos
        for (int i = 0; i < 3; i++) commit_acked();
        step(1, 1, 0, 1, 0, 0);            // offer open at pos 3
        // Asynchronous reset mid-offer, between clock edges.
        @(negedge Clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", int'(lif.Valid), 0);
        chk("arst_pos",   int'(pos),       0);
        chk("arst_sel",   int'(sel_letter), 8'h41);
        model_reset();
        @(posedge Clk); model_step(); expq.push_back(model_view()); #1;
        reset = 1'b1;
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 18), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 40));
        end
        idle(2);
        @(negedge Clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
